load_store_unit: RTL and testbench

Memory stage of the RV64IM core, directly downstream of the execute-stage ALU. It consumes the ALU result as the effective address for loads (opcode 0000011) and stores (opcode 0100011). It performs one aligned 64-bit data-memory transaction over a request/grant/response handshake, then returns sign- or zero-extended load data to writeback. Non-memory instructions pass the ALU result through untouched.

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_store_unit_align.sv | 40 ++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared core definitions: decoded instruction view, memory opcodes and access-size encodings.
// Also the alignment/legality check used by the load/store unit.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef struct packed {
        logic [2:0] funct3;
        logic [6:0] opcode;
    } decoded_inst_t;

    // An illegal size encoding is reported the same way as a misaligned address.
    function automatic logic access_fault(input logic is_store, input logic [2:0] funct3,
                                          input logic [2:0] addr_lo);
        logic bad_f3;
        bad_f3 = is_store ? funct3[2] : (funct3 == 3'b111);
        case (funct3[1:0])
            2'b00:   return bad_f3;
            2'b01:   return bad_f3 | addr_lo[0];
            2'b10:   return bad_f3 | (addr_lo[1:0] != 2'b00);
            default: return bad_f3 | (addr_lo != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data alignment: load lane extraction with sign/zero extension,
// and store lane shifting with byte-strobe generation.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      size_mask;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_data = {56'b0, shifted[7:0]};
            F3_HU:   load_data = {48'b0, shifted[15:0]};
            F3_WU:   load_data = {32'b0, shifted[31:0]};
            default: load_data = shifted;
        endcase

        case (funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
        wdata = store_data << {addr_lo, 3'b000};
        wstrb = size_mask << addr_lo;
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one aligned doubleword transaction per load/store over req/gnt/rvalid,
// non-memory results pass straight through to writeback.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  decoded_inst_t   instr,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic            misalign_exc
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t          state;
    logic [2:0]      funct3_q;
    logic [2:0]      addr_lo_q;
    logic            is_store_q;

    logic            accept, is_load, is_store, is_mem, fault;
    logic [2:0]      align_f3, align_addr;
    logic [XLEN-1:0] load_data, wdata;
    logic [7:0]      wstrb;

    assign accept   = in_valid && in_ready;
    assign is_load  = (instr.opcode == OP_LOAD);
    assign is_store = (instr.opcode == OP_STORE);
    assign is_mem   = is_load || is_store;
    assign fault    = access_fault(is_store, instr.funct3, alu_result[2:0]);

    // One aligner serves both directions: live inputs while idle, captured fields afterwards.
    assign align_f3   = (state == StIdle) ? instr.funct3     : funct3_q;
    assign align_addr = (state == StIdle) ? alu_result[2:0]  : addr_lo_q;

    lsu_align u_align (
        .funct3     (align_f3),
        .addr_lo    (align_addr),
        .rdata      (mem_rdata),
        .store_data (store_data),
        .load_data  (load_data),
        .wdata      (wdata),
        .wstrb      (wstrb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            in_ready     <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_wb_en    <= 1'b0;
            misalign_exc <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            is_store_q   <= 1'b0;
        end else begin
            case (state)
                StIdle: if (accept) begin
                    in_ready   <= 1'b0;
                    out_rd     <= rd_in;
                    funct3_q   <= instr.funct3;
                    addr_lo_q  <= alu_result[2:0];
                    is_store_q <= is_store;
                    if (is_mem && !fault) begin
                        state     <= StReq;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {alu_result[XLEN-1:3], 3'b000};
                        mem_wdata <= is_store ? wdata : '0;
                        mem_wstrb <= is_store ? wstrb : '0;
                    end else begin
                        state        <= StResp;
                        out_valid    <= 1'b1;
                        out_data     <= is_mem ? '0 : alu_result;
                        out_wb_en    <= !is_mem;
                        misalign_exc <= is_mem;
                    end
                end
                StReq: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (is_store_q) begin
                        state     <= StResp;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_wb_en <= 1'b0;
                    end else begin
                        state <= StWait;
                    end
                end
                StWait: if (mem_rvalid) begin
                    state     <= StResp;
                    out_valid <= 1'b1;
                    out_data  <= load_data;
                    out_wb_en <= 1'b1;
                end
                StResp: if (out_ready) begin
                    state        <= StIdle;
                    in_ready     <= 1'b1;
                    out_valid    <= 1'b0;
                    out_wb_en    <= 1'b0;
                    misalign_exc <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, pass-through
// backpressure and reset in the middle of a load.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    decoded_inst_t instr;
    logic [63:0]   alu_result;
    logic [63:0]   store_data;
    logic [4:0]    rd_in;
    logic          mem_req;
    logic          mem_we;
    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wstrb;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [63:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [4:0]    out_rd;
    logic          out_wb_en;
    logic          misalign_exc;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_in        (rd_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_wb_en    (out_wb_en),
        .misalign_exc (misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [4:0] rd);
        in_valid   = 1'b1;
        instr      = '{funct3: f3, opcode: op};
        alu_result = addr;
        store_data = sdata;
        rd_in      = rd;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("retire_out_valid", {63'b0, out_valid}, 64'd0);
        check("retire_in_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        instr = '{funct3: 3'b000, opcode: 7'b0};
        alu_result = '0;
        store_data = '0;
        rd_in = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_mem_req", {63'b0, mem_req}, 64'd0);
        check("rst_mem_wstrb", {56'b0, mem_wstrb}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // LB at 0x1003: byte 3 of the doubleword is 0x80, sign-extended.
        issue(OP_LOAD, F3_B, 64'h1003, 64'd0, 5'd5);
        check("lb_mem_req", {63'b0, mem_req}, 64'd1);
        check("lb_mem_we", {63'b0, mem_we}, 64'd0);
        check("lb_mem_addr", mem_addr, 64'h1000);
        check("lb_in_ready", {63'b0, in_ready}, 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("lb_req_dropped", {63'b0, mem_req}, 64'd0);
        check("lb_no_early_valid", {63'b0, out_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 64'h0000_0000_8000_0000;
        step();
        mem_rvalid = 1'b0;
        check("lb_out_valid", {63'b0, out_valid}, 64'd1);
        check("lb_out_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_wb_en", {63'b0, out_wb_en}, 64'd1);
        check("lb_out_rd", {59'b0, out_rd}, 64'd5);
        check("lb_misalign", {63'b0, misalign_exc}, 64'd0);
        retire();

        // LHU at 0x2006 with one idle cycle between grant and data.
        issue(OP_LOAD, F3_HU, 64'h2006, 64'd0, 5'd7);
        check("lhu_mem_addr", mem_addr, 64'h2000);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        check("lhu_wait_valid", {63'b0, out_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 64'hBEEF_0000_0000_0000;
        step();
        mem_rvalid = 1'b0;
        check("lhu_out_data", out_data, 64'h0000_0000_0000_BEEF);
        check("lhu_out_valid", {63'b0, out_valid}, 64'd1);
        retire();

        // SH at 0x1006, grant withheld three cycles while inputs wander.
        issue(OP_STORE, F3_H, 64'h1006, 64'h1234_BEEF, 5'd0);
        for (int i = 0; i < 3; i++) begin
            alu_result = 64'hDEAD_0000 + 64'(i);
            store_data = 64'hFFFF_FFFF_FFFF_FFFF;
            check("sh_mem_req", {63'b0, mem_req}, 64'd1);
            check("sh_mem_we", {63'b0, mem_we}, 64'd1);
            check("sh_mem_addr", mem_addr, 64'h1000);
            check("sh_mem_wstrb", {56'b0, mem_wstrb}, 64'h00C0);
            check("sh_mem_wdata", mem_wdata, 64'hBEEF_0000_0000_0000);
            step();
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("sh_out_valid", {63'b0, out_valid}, 64'd1);
        check("sh_wb_en", {63'b0, out_wb_en}, 64'd0);
        check("sh_out_data", out_data, 64'd0);
        check("sh_req_after_gnt", {63'b0, mem_req}, 64'd0);
        retire();

        // SB at the top byte lane.
        issue(OP_STORE, F3_B, 64'h4007, 64'h0000_00AB, 5'd0);
        check("sb_mem_wstrb", {56'b0, mem_wstrb}, 64'h0080);
        check("sb_mem_wdata", mem_wdata, 64'hAB00_0000_0000_0000);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        retire();

        // LW at 0x1002 is misaligned: no request, exception at T+1.
        issue(OP_LOAD, F3_W, 64'h1002, 64'd0, 5'd9);
        check("lw_mis_mem_req", {63'b0, mem_req}, 64'd0);
        check("lw_mis_out_valid", {63'b0, out_valid}, 64'd1);
        check("lw_mis_exc", {63'b0, misalign_exc}, 64'd1);
        check("lw_mis_wb_en", {63'b0, out_wb_en}, 64'd0);
        retire();

        // Illegal load size (funct3 111) reports as misaligned.
        issue(OP_LOAD, 3'b111, 64'h1000, 64'd0, 5'd9);
        check("ld111_exc", {63'b0, misalign_exc}, 64'd1);
        check("ld111_mem_req", {63'b0, mem_req}, 64'd0);
        retire();

        // ADD pass-through held under four cycles of backpressure.
        issue(OP_ADD, 3'b000, 64'h55, 64'd0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            alu_result = 64'h99;
            check("add_out_valid", {63'b0, out_valid}, 64'd1);
            check("add_out_data", out_data, 64'h55);
            check("add_in_ready", {63'b0, in_ready}, 64'd0);
            check("add_wb_en", {63'b0, out_wb_en}, 64'd1);
            step();
        end
        retire();

        // Reset while waiting on load data, then a stale response.
        issue(OP_LOAD, F3_D, 64'h3000, 64'd0, 5'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("mid_rst_mem_addr", mem_addr, 64'd0);
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 64'h1111_2222_3333_4444;
        step();
        mem_rvalid = 1'b0;
        check("stale_out_valid", {63'b0, out_valid}, 64'd0);
        check("stale_in_ready", {63'b0, in_ready}, 64'd1);
        check("stale_out_data", out_data, 64'd0);
        step();
        check("stale_out_valid_2", {63'b0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
